// File: rtl/tetris_pkg.sv
// Command encodings and PS/2 scancode constants shared by the keyboard decoder
// and the game controller.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE   = 3'b000,
    CMD_DOWN   = 3'b100,
    CMD_LEFT   = 3'b101,
    CMD_RIGHT  = 3'b110,
    CMD_ROTATE = 3'b111
  } cmd_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // Extended (E0-prefixed) arrow keys
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;

  // Plain WASD keys
  localparam logic [7:0] SC_KEY_S = 8'h1B;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_D = 8'h23;
  localparam logic [7:0] SC_KEY_W = 8'h1D;

  function automatic cmd_t mapScancode(input logic [7:0] code, input logic ext);
    cmd_t cmd;
    cmd = CMD_IDLE;
    if (ext) begin
      case (code)
        SC_ARROW_DOWN:  cmd = CMD_DOWN;
        SC_ARROW_LEFT:  cmd = CMD_LEFT;
        SC_ARROW_RIGHT: cmd = CMD_RIGHT;
        SC_ARROW_UP:    cmd = CMD_ROTATE;
        default:        cmd = CMD_IDLE;
      endcase
    end else begin
      case (code)
        SC_KEY_S: cmd = CMD_DOWN;
        SC_KEY_A: cmd = CMD_LEFT;
        SC_KEY_D: cmd = CMD_RIGHT;
        SC_KEY_W: cmd = CMD_ROTATE;
        default:  cmd = CMD_IDLE;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 bit-level receiver: synchronizers, falling-edge detect, frame FSM, timeout.
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_error
);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityCheck = 1'b1;
`else
  localparam bit ParityCheck = 1'b0;
`endif

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic [SYNC_STAGES-1:0] clkSync;
  logic [SYNC_STAGES-1:0] dataSync;
  logic                   prevClk;
  logic                   syncClk;
  logic                   syncData;
  logic                   fall;

  rx_state_t  state;
  logic [2:0] bitCnt;
  logic [7:0] shiftReg;
  logic       parityBit;
  logic [TW-1:0] timeoutCnt;

  logic timeoutHit;
  logic stopEdge;
  logic parityBad;

  // Idle level is 1 so leaving reset never looks like a falling edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clkSync  <= '1;
      dataSync <= '1;
      prevClk  <= 1'b1;
    end else begin
      clkSync[0]  <= ps2_clk;
      dataSync[0] <= ps2_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        clkSync[i]  <= clkSync[i-1];
        dataSync[i] <= dataSync[i-1];
      end
      prevClk <= syncClk;
    end
  end

  assign syncClk  = clkSync[SYNC_STAGES-1];
  assign syncData = dataSync[SYNC_STAGES-1];
  assign fall     = prevClk & ~syncClk;

  assign timeoutHit = (state != IDLE) && !fall && (timeoutCnt == TW'(TIMEOUT_CYCLES - 1));
  assign stopEdge   = fall && (state == STOP);
  // Odd parity: an even total weight over data plus parity bit is a bad frame
  assign parityBad  = ParityCheck & ~(^{shiftReg, parityBit});

  assign byte_data  = shiftReg;
  assign byte_valid = stopEdge && syncData && !parityBad;
  assign byte_error = (stopEdge && (!syncData || parityBad)) || timeoutHit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bitCnt     <= '0;
      shiftReg   <= '0;
      parityBit  <= 1'b0;
      timeoutCnt <= '0;
    end else begin
      if (state == IDLE || fall) timeoutCnt <= '0;
      else                       timeoutCnt <= timeoutCnt + 1'b1;

      if (timeoutHit) begin
        state    <= IDLE;
        bitCnt   <= '0;
        shiftReg <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!syncData) begin
              state  <= DATA;
              bitCnt <= '0;
            end
          end
          DATA: begin
            shiftReg <= {syncData, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parityBit <= syncData;
            state     <= STOP;
          end
          STOP: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_command_decoder.sv
// Turns PS/2 keyboard bytes into one-cycle Tetris commands (E0/F0 prefix handling).
// Parity checking in the receiver is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_command_decoder
  import tetris_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] keyboard_signal,
  output logic [7:0] last_scancode,
  output logic       frame_error
);

  logic [7:0] rxByte;
  logic       rxValid;
  logic       rxError;
  logic       ext;
  logic       brk;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) uRx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_data  (rxByte),
    .byte_valid (rxValid),
    .byte_error (rxError)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      keyboard_signal <= CMD_IDLE;
      last_scancode   <= '0;
      frame_error     <= 1'b0;
      ext             <= 1'b0;
      brk             <= 1'b0;
    end else begin
      keyboard_signal <= CMD_IDLE;
      frame_error     <= rxError;
      if (rxError) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rxValid) begin
        last_scancode <= rxByte;
        if (rxByte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rxByte == SC_BREAK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk) keyboard_signal <= mapScancode(rxByte, ext);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Directed bench for ps2_command_decoder; PS/2 frames are bit-banged slowly vs clk.
module tb_ps2_command_decoder;

  localparam int unsigned TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [2:0] keyboardSignal;
  logic [7:0] lastScancode;
  logic       frameError;

  int checks = 0;
  int errors = 0;

  int cmdCycles = 0;
  int cmdRises = 0;
  int errCycles = 0;
  int errRises = 0;
  logic [2:0] lastCmd = 3'b000;
  logic [2:0] prevKs = 3'b000;
  logic       prevFe = 1'b0;

  int sCmdCycles, sCmdRises, sErrCycles, sErrRises;

  ps2_command_decoder #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ps2_clk         (ps2Clk),
    .ps2_data        (ps2Data),
    .keyboard_signal (keyboardSignal),
    .last_scancode   (lastScancode),
    .frame_error     (frameError)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (keyboardSignal != 3'b000) begin
      cmdCycles <= cmdCycles + 1;
      lastCmd   <= keyboardSignal;
      if (prevKs == 3'b000) cmdRises <= cmdRises + 1;
    end
    if (frameError) begin
      errCycles <= errCycles + 1;
      if (!prevFe) errRises <= errRises + 1;
    end
    prevKs <= keyboardSignal;
    prevFe <= frameError;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sendBit(input logic b);
    ps2Data = b;
    waitClk(4);
    ps2Clk = 1'b0;
    waitClk(4);
    ps2Clk = 1'b1;
    waitClk(4);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic goodParity, input logic stopBit);
    logic p;
    p = goodParity ? ~(^b) : (^b);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(p);
    sendBit(stopBit);
    ps2Data = 1'b1;
    waitClk(10);
  endtask

  task automatic snap();
    @(negedge clk);
    sCmdCycles = cmdCycles;
    sCmdRises  = cmdRises;
    sErrCycles = errCycles;
    sErrRises  = errRises;
  endtask

  task automatic checkCounts(input string name, input int expCmd, input int expErr);
    @(negedge clk);
    checks++;
    if (cmdRises - sCmdRises !== expCmd) begin
      errors++;
      $display("FAIL %s cmd pulses: got %0d expected %0d", name, cmdRises - sCmdRises, expCmd);
    end
    checks++;
    if (cmdCycles - sCmdCycles !== expCmd) begin
      errors++;
      $display("FAIL %s cmd cycles: got %0d expected %0d", name, cmdCycles - sCmdCycles, expCmd);
    end
    checks++;
    if (errRises - sErrRises !== expErr) begin
      errors++;
      $display("FAIL %s error pulses: got %0d expected %0d", name, errRises - sErrRises, expErr);
    end
    checks++;
    if (errCycles - sErrCycles !== expErr) begin
      errors++;
      $display("FAIL %s error cycles: got %0d expected %0d", name, errCycles - sErrCycles, expErr);
    end
  endtask

  task automatic checkCmd(input string name, input logic [2:0] expCmd, input logic [7:0] expCode);
    @(negedge clk);
    checks++;
    if (lastCmd !== expCmd) begin
      errors++;
      $display("FAIL %s command: got %b expected %b", name, lastCmd, expCmd);
    end
    checks++;
    if (lastScancode !== expCode) begin
      errors++;
      $display("FAIL %s last_scancode: got %h expected %h", name, lastScancode, expCode);
    end
  endtask

  task automatic checkResetOutputs(input string name);
    @(negedge clk);
    checks++;
    if (keyboardSignal !== 3'b000 || lastScancode !== 8'h00 || frameError !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: got ks=%b sc=%h fe=%b expected ks=000 sc=00 fe=0",
               name, keyboardSignal, lastScancode, frameError);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    waitClk(3);
    checkResetOutputs("reset");
    rst = 1'b0;
    snap();
    waitClk(20);
    checkCounts("reset_quiet", 0, 0);
  endtask

  task automatic test_ext_arrow();
    snap();
    sendFrame(8'hE0, 1'b1, 1'b1);
    sendFrame(8'h6B, 1'b1, 1'b1);
    checkCounts("ext_left", 1, 0);
    checkCmd("ext_left", 3'b101, 8'h6B);
  endtask

  task automatic test_break();
    snap();
    sendFrame(8'hE0, 1'b1, 1'b1);
    sendFrame(8'hF0, 1'b1, 1'b1);
    sendFrame(8'h6B, 1'b1, 1'b1);
    checkCounts("release", 0, 0);
    snap();
    sendFrame(8'h1C, 1'b1, 1'b1);
    checkCounts("after_release", 1, 0);
    checkCmd("after_release", 3'b101, 8'h1C);
  endtask

  task automatic test_back_to_back();
    snap();
    for (int k = 0; k < 3; k++) sendFrame(8'h1D, 1'b1, 1'b1);
    checkCounts("typematic", 3, 0);
    checkCmd("typematic", 3'b111, 8'h1D);
  endtask

  task automatic test_bad_stop();
    snap();
    sendFrame(8'hE0, 1'b1, 1'b1);
    sendFrame(8'h1C, 1'b1, 1'b0);
    checkCounts("bad_stop", 0, 1);
    checkCmd("bad_stop", 3'b111, 8'hE0);
    snap();
    sendFrame(8'h1C, 1'b1, 1'b1);
    checkCounts("flags_cleared", 1, 0);
    checkCmd("flags_cleared", 3'b101, 8'h1C);
  endtask

  task automatic test_timeout();
    snap();
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b0);
    ps2Data = 1'b1;
    waitClk(TO + 10);
    checkCounts("timeout", 0, 1);
    snap();
    sendFrame(8'h23, 1'b1, 1'b1);
    checkCounts("post_timeout", 1, 0);
    checkCmd("post_timeout", 3'b110, 8'h23);
  endtask

  task automatic test_parity();
    snap();
    sendFrame(8'h1B, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checkCounts("even_parity", 0, 1);
    checkCmd("even_parity", 3'b110, 8'h23);
`else
    checkCounts("even_parity", 1, 0);
    checkCmd("even_parity", 3'b100, 8'h1B);
`endif
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    b = 8'h1D;
    sendFrame(8'hE0, 1'b1, 1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(b[i]);
    rst = 1'b1;
    waitClk(2);
    checkResetOutputs("mid_reset");
    rst = 1'b0;
    snap();
    for (int i = 4; i < 8; i++) sendBit(b[i]);
    sendBit(~(^b));
    sendBit(1'b1);
    ps2Data = 1'b1;
    waitClk(TO + 10);
    @(negedge clk);
    checks++;
    if (cmdRises - sCmdRises !== 0) begin
      errors++;
      $display("FAIL mid_reset_tail cmd pulses: got %0d expected 0", cmdRises - sCmdRises);
    end
    snap();
    sendFrame(8'h1B, 1'b1, 1'b1);
    checkCounts("after_mid_reset", 1, 0);
    checkCmd("after_mid_reset", 3'b100, 8'h1B);
  endtask

  initial begin
    test_reset();
    test_ext_arrow();
    test_break();
    test_back_to_back();
    test_bad_stop();
    test_timeout();
    test_parity();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
